// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the core's load/store port. It accepts one
//   request at a time, waits WAIT_CYCLES clock cycles, performs an RV32I
//   byte/half/word load or store, and returns the result on a response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid && ready. The request side is ready only in IDLE. The
//   response side holds rsp_valid, rsp_rdata and rsp_err stable until
//   rsp_ready is seen.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake
//   req_we                  1 = store, 0 = load
//   req_funct3              RV32I size code (b, h, w, bu, hu)
//   req_addr                byte address; word index is addr[31:2]
//   req_wdata               right-aligned store data
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata               extended load data (0 for stores and errors)
//   rsp_err                 request rejected
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        do_access;
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] word_idx;
  logic [AW-1:0] idx;
  logic        bad_f3, misaligned, out_of_range, acc_err;
  logic [31:0] rd_word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic        mem_we;

  assign accept = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request inputs are used; otherwise the latched copies are used.
  assign do_access = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign acc_we    = (state_q == S_IDLE) ? req_we     : we_q;
  assign acc_f3    = (state_q == S_IDLE) ? req_funct3 : f3_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;

  assign word_idx = {2'b00, acc_addr[31:2]};
  assign idx      = acc_addr[AW+1:2];

  // Error decode
  always_comb begin
    bad_f3 = 1'b0;
    case (acc_f3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = acc_we;  // unsigned sizes are load-only
      default:                bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (acc_f3)
      3'b001, 3'b101: misaligned = acc_addr[0];
      3'b010:         misaligned = (acc_addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (word_idx >= 32'(DEPTH_WORDS));
  assign acc_err      = bad_f3 || misaligned || out_of_range;

  // Load path
  assign rd_word = mem[idx];
  assign bsel    = rd_word[8*acc_addr[1:0] +: 8];
  assign hsel    = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'h0;
    case (acc_f3)
      3'b000:  ld_data = {{24{bsel[7]}}, bsel};
      3'b001:  ld_data = {{16{hsel[15]}}, hsel};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, bsel};
      3'b101:  ld_data = {16'h0, hsel};
      default: ld_data = 32'h0;
    endcase
  end

  // Store path: replicate the data across lanes, byte enables pick the lanes.
  always_comb begin
    be      = 4'b0000;
    st_data = acc_wdata;
    case (acc_f3)
      3'b000: begin
        be      = 4'b0001 << acc_addr[1:0];
        st_data = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        be      = acc_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      3'b010: begin
        be      = 4'b1111;
        st_data = acc_wdata;
      end
      default: begin
        be      = 4'b0000;
        st_data = acc_wdata;
      end
    endcase
  end

  assign mem_we = do_access && acc_we && !acc_err && !reset;

  // Storage is intentionally outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= 4'(WAIT_CYCLES);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'h0 : ld_data;
      end else if ((state_q == S_RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

endmodule
